// File: rtl/risc_pkg.sv
// Shared types and constants for the 16-bit RISC core front end.
// Provides: WORD_W, DEFAULT_RESET_PC and the fetch_state_t sequencer states.
// No ports; imported by the fetch interface, adder and fetch unit.
package risc_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundles the instruction-memory, decode and redirect signals of the fetch unit.
// master: fetch unit side (drives imem_req/imem_addr/instr_*/pc_out).
// slave : environment side (memory, decode and execute driving ack/rdata/ready/br_*).
interface pc_fetch_unit_if;
  import risc_pkg::*;

  // instruction memory, req/ack
  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_ack;
  logic [WORD_W-1:0] imem_rdata;

  // decode, valid/ready
  logic              instr_valid;
  logic              instr_ready;
  logic [WORD_W-1:0] instr_out;
  logic [WORD_W-1:0] pc_out;

  // redirect from execute
  logic              br_en;
  logic              br_rel;
  logic [WORD_W-1:0] br_offset;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, pc_out,
    input  imem_ack, imem_rdata, instr_ready, br_en, br_rel, br_offset
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, pc_out,
    output imem_ack, imem_rdata, instr_ready, br_en, br_rel, br_offset
  );

endinterface

// File: rtl/adder16bit.sv
// Core 16-bit adder, used by fetch for next-PC and branch-target computation.
// Latency: combinational. Backpressure: none.
// Ports: a, b (operands), sum = a + b modulo 2^16 (carry discarded).
module adder16bit
  import risc_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch sequencer: holds the PC, fetches words over req/ack and
// presents them to decode over valid/ready; redirects from execute take priority.
// Latency: ack -> instr_valid next cycle; accept -> next imem_req next cycle.
// Backpressure: instr_ready low parks the unit in HOLD with all outputs frozen.
// Ports: clk, rst (sync, active-high), bus (pc_fetch_unit_if.master),
//        fetch_count[15:0] only when PC_FETCH_PERF_EN is defined.
module pc_fetch_unit
  import risc_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  pc_fetch_unit_if.master     bus
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [WORD_W-1:0]   fetch_count
`endif
);

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] req_addr_q, req_addr_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pc_out_q, pc_out_d;

  logic [WORD_W-1:0] adder_b;
  logic [WORD_W-1:0] adder_sum;
  logic [WORD_W-1:0] br_target;

  // One adder serves both sequential increment and relative branches; the
  // relative offset is only steered in when a relative redirect is present.
  assign adder_b = (bus.br_en && bus.br_rel) ? bus.br_offset : 16'd1;

  adder16bit u_adder (
    .a   (pc_q),
    .b   (adder_b),
    .sum (adder_sum)
  );

  assign br_target = bus.br_rel ? adder_sum : bus.br_offset;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;

    case (state_q)
      RESET: begin
        state_d = FETCH;
        if (bus.br_en) begin
          pc_d       = br_target;
          req_addr_d = br_target;
        end else begin
          req_addr_d = pc_q;
        end
      end

      FETCH: begin
        if (bus.br_en) begin
          pc_d = br_target;
          if (bus.imem_ack) begin
            // Returned word is stale; restart straight at the target.
            req_addr_d = br_target;
          end else begin
            // Request must complete at its original address before we can
            // reissue, so park in DRAIN.
            state_d = DRAIN;
          end
        end else if (bus.imem_ack) begin
          instr_d  = bus.imem_rdata;
          pc_out_d = pc_q;
          state_d  = HOLD;
        end
      end

      HOLD: begin
        // pc_q equals pc_out_q here, so relative targets are based on pc_out.
        if (bus.br_en) begin
          pc_d       = br_target;
          req_addr_d = br_target;
          state_d    = FETCH;
        end else if (bus.instr_ready) begin
          pc_d       = adder_sum;
          req_addr_d = adder_sum;
          state_d    = FETCH;
        end
      end

      DRAIN: begin
        if (bus.br_en) begin
          pc_d = br_target;
        end
        if (bus.imem_ack) begin
          // Data discarded; the most recent redirect wins.
          req_addr_d = bus.br_en ? br_target : pc_q;
          state_d    = FETCH;
        end
      end

      default: begin
        state_d = RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RESET;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      instr_q    <= '0;
      pc_out_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
    end
  end

  // Outputs are decoded only from flops, never from inputs.
  assign bus.imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign bus.imem_addr   = req_addr_q;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pc_out_q;

`ifdef PC_FETCH_PERF_EN
  logic [WORD_W-1:0] fetch_count_q, fetch_count_d;

  // An accept coinciding with a redirect still transfers, so it counts.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if ((state_q == HOLD) && bus.instr_ready) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: two instances, default RESET_PC and 16'hFFFF.
module tb_pc_fetch_unit;
  import risc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_fetch_unit_if bus1 ();
  pc_fetch_unit_if bus2 ();

`ifdef PC_FETCH_PERF_EN
  logic [15:0] fcnt1;
  logic [15:0] fcnt2;
`endif

  pc_fetch_unit #(.RESET_PC(16'h0000)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
`ifdef PC_FETCH_PERF_EN
    ,
    .fetch_count (fcnt1)
`endif
  );

  pc_fetch_unit #(.RESET_PC(16'hFFFF)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2.master)
`ifdef PC_FETCH_PERF_EN
    ,
    .fetch_count (fcnt2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst  = 1'b1;
    rst2 = 1'b1;
    bus1.imem_ack = 1'b0; bus1.imem_rdata = '0; bus1.instr_ready = 1'b1;
    bus1.br_en = 1'b0; bus1.br_rel = 1'b0; bus1.br_offset = '0;
    bus2.imem_ack = 1'b0; bus2.imem_rdata = '0; bus2.instr_ready = 1'b1;
    bus2.br_en = 1'b0; bus2.br_rel = 1'b0; bus2.br_offset = '0;

    // Reset state
    tick(); tick();
    chk("rst_req",   16'(bus1.imem_req), 16'h0);
    chk("rst_addr",  bus1.imem_addr, 16'h0000);
    chk("rst_valid", 16'(bus1.instr_valid), 16'h0);
    chk("rst_instr", bus1.instr_out, 16'h0000);
    chk("rst_pcout", bus1.pc_out, 16'h0000);
`ifdef PC_FETCH_PERF_EN
    chk("rst_cnt", fcnt1, 16'h0000);
`endif

    // Release reset: request from the next cycle
    rst = 1'b0;
    tick();

    // Zero-wait stream, ready high: pc 0..3, valid every other cycle
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("seq_req%0d", i),   16'(bus1.imem_req), 16'h1);
      chk($sformatf("seq_addr%0d", i),  bus1.imem_addr, 16'(i));
      chk($sformatf("seq_nv%0d", i),    16'(bus1.instr_valid), 16'h0);
      bus1.imem_ack = 1'b1;
      bus1.imem_rdata = 16'(i) ^ 16'hA5A5;
      tick();
      bus1.imem_ack = 1'b0;
      chk($sformatf("seq_valid%0d", i), 16'(bus1.instr_valid), 16'h1);
      chk($sformatf("seq_noreq%0d", i), 16'(bus1.imem_req), 16'h0);
      chk($sformatf("seq_instr%0d", i), bus1.instr_out, 16'(i) ^ 16'hA5A5);
      chk($sformatf("seq_pc%0d", i),    bus1.pc_out, 16'(i));
      tick();
    end

    // Backpressure: hold instruction at pc 4 for 5 cycles
    chk("bp_addr", bus1.imem_addr, 16'h0004);
    bus1.instr_ready = 1'b0;
    bus1.imem_ack = 1'b1;
    bus1.imem_rdata = 16'h0004 ^ 16'hA5A5;
    tick();
    bus1.imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_valid%0d", i), 16'(bus1.instr_valid), 16'h1);
      chk($sformatf("bp_req%0d", i),   16'(bus1.imem_req), 16'h0);
      chk($sformatf("bp_instr%0d", i), bus1.instr_out, 16'hA5A1);
      chk($sformatf("bp_pc%0d", i),    bus1.pc_out, 16'h0004);
    end
    bus1.instr_ready = 1'b1;
    tick();
    chk("bp_next_addr", bus1.imem_addr, 16'h0005);
    chk("bp_next_req",  16'(bus1.imem_req), 16'h1);

    // Absolute redirect in FETCH with ack: word discarded, refetch at 0x10
    bus1.br_en = 1'b1; bus1.br_rel = 1'b0; bus1.br_offset = 16'h0010;
    bus1.imem_ack = 1'b1; bus1.imem_rdata = 16'hBEEF;
    tick();
    bus1.br_en = 1'b0; bus1.imem_ack = 1'b0;
    chk("fbr_req",   16'(bus1.imem_req), 16'h1);
    chk("fbr_addr",  bus1.imem_addr, 16'h0010);
    chk("fbr_valid", 16'(bus1.instr_valid), 16'h0);

    // Relative redirect in HOLD at pc_out 0x10, offset -4 -> 0x000C
    bus1.instr_ready = 1'b0;
    bus1.imem_ack = 1'b1; bus1.imem_rdata = 16'h0010 ^ 16'hA5A5;
    tick();
    bus1.imem_ack = 1'b0;
    chk("hbr_pcout", bus1.pc_out, 16'h0010);
    bus1.br_en = 1'b1; bus1.br_rel = 1'b1; bus1.br_offset = 16'hFFFC;
    bus1.instr_ready = 1'b1;
    tick();
    bus1.br_en = 1'b0; bus1.br_rel = 1'b0;
    chk("hbr_req",   16'(bus1.imem_req), 16'h1);
    chk("hbr_addr",  bus1.imem_addr, 16'h000C);
    chk("hbr_valid", 16'(bus1.instr_valid), 16'h0);
    bus1.imem_ack = 1'b1; bus1.imem_rdata = 16'h000C ^ 16'hA5A5;
    tick();
    bus1.imem_ack = 1'b0;
    chk("hbr_instr", bus1.instr_out, 16'hA5A9);
    chk("hbr_pc",    bus1.pc_out, 16'h000C);
    tick();
    chk("hbr_next", bus1.imem_addr, 16'h000D);

    // Redirect in FETCH without ack: DRAIN at old address, ack after 3 cycles
    bus1.br_en = 1'b1; bus1.br_rel = 1'b0; bus1.br_offset = 16'h0200;
    tick();
    bus1.br_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dr_req%0d", i),   16'(bus1.imem_req), 16'h1);
      chk($sformatf("dr_addr%0d", i),  bus1.imem_addr, 16'h000D);
      chk($sformatf("dr_valid%0d", i), 16'(bus1.instr_valid), 16'h0);
      if (i < 2) tick();
    end
    bus1.imem_ack = 1'b1; bus1.imem_rdata = 16'hDEAD;
    tick();
    bus1.imem_ack = 1'b0;
    chk("dr_new_addr", bus1.imem_addr, 16'h0200);
    chk("dr_new_req",  16'(bus1.imem_req), 16'h1);
    chk("dr_discard",  16'(bus1.instr_valid), 16'h0);
    bus1.imem_ack = 1'b1; bus1.imem_rdata = 16'h0200 ^ 16'hA5A5;
    tick();
    bus1.imem_ack = 1'b0;
    chk("dr_instr", bus1.instr_out, 16'hA7A5);
    chk("dr_pc",    bus1.pc_out, 16'h0200);
    tick();
    chk("dr_next", bus1.imem_addr, 16'h0201);
`ifdef PC_FETCH_PERF_EN
    chk("cnt_total", fcnt1, 16'h0008);
`endif

    // Reset while FETCH waits for ack
    rst = 1'b1;
    tick();
    chk("mrst_req",   16'(bus1.imem_req), 16'h0);
    chk("mrst_valid", 16'(bus1.instr_valid), 16'h0);
    chk("mrst_addr",  bus1.imem_addr, 16'h0000);
`ifdef PC_FETCH_PERF_EN
    chk("mrst_cnt", fcnt1, 16'h0000);
`endif
    rst = 1'b0;
    tick();
    chk("mrst_refetch_req",  16'(bus1.imem_req), 16'h1);
    chk("mrst_refetch_addr", bus1.imem_addr, 16'h0000);

    // RESET_PC = 0xFFFF: PC wraps to 0 after one accept
    chk("w_rst_addr", bus2.imem_addr, 16'hFFFF);
    chk("w_rst_pc",   bus2.pc_out, 16'hFFFF);
    rst2 = 1'b0;
    tick();
    chk("w_addr0", bus2.imem_addr, 16'hFFFF);
    bus2.imem_ack = 1'b1; bus2.imem_rdata = 16'h1234;
    tick();
    bus2.imem_ack = 1'b0;
    chk("w_pc",    bus2.pc_out, 16'hFFFF);
    chk("w_instr", bus2.instr_out, 16'h1234);
    tick();
    chk("w_wrap_addr", bus2.imem_addr, 16'h0000);
    chk("w_wrap_req",  16'(bus2.imem_req), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
